// File: rtl/bus_mgr_pkg.sv
// Shared types and constants for the command-driven bus burst manager.
// Imported by the top-level FSM and by the testbench.
package bus_mgr_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_WBUS = 3'd2,
      S_RBUS = 3'd3,
      S_DONE = 3'd4
   } mgr_state_e;

   localparam logic RESP_OK  = 1'b0;
   localparam logic RESP_ERR = 1'b1;

   // A burst must move at least one beat and must fit in the write buffer.
   function automatic logic len_is_legal(input int unsigned len, input int unsigned max_beats);
      return (len != 0) && (len <= max_beats);
   endfunction

endpackage

// File: rtl/burst_buffer.sv
// Register file that stages write beats before they go out on the bus.
// Synchronous write port, asynchronous read port.
module burst_buffer #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately left unreset: every beat is written before it is read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bus_burst_manager.sv
// Command-driven bus burst engine: stages write data, drives the shared bus,
// accumulates beat errors, aborts on slave timeout and reports one completion per command.
module bus_burst_manager
   import bus_mgr_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 16,
   parameter int LEN_W     = $clog2(MAX_BEATS + 1),
   parameter int TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wd_valid,
   output logic              wd_ready,
   input  logic [DATA_W-1:0] wd_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              done,
   output logic              done_err,
   output logic              done_timeout,
   output logic              bus_valid,
   output logic              bus_wr_en,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [LEN_W-1:0]  bus_burst_len,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ready,
   input  logic              bus_resp,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int IDX_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam int STALL_W = $clog2(TIMEOUT + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

   mgr_state_e state, next_state;

   logic               wr_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   cnt;
   logic [STALL_W-1:0] stall_cnt;
   logic               err_q;
   logic               timeout_q;
   logic               cmd_ready_q;
   logic               rd_valid_q;
   logic               rd_last_q;
   logic [DATA_W-1:0]  rd_data_q;
   logic [DATA_W-1:0]  buf_rdata;

   logic in_bus;
   logic last_beat;
   logic cmd_legal;
   logic cmd_fire;
   logic wd_fire;
   logic beat_fire;
   logic stall_fire;
   logic timeout_hit;

   assign in_bus    = (state == S_WBUS) || (state == S_RBUS);
   assign last_beat = (cnt == (len_q - LEN_W'(1)));
   assign cmd_legal = len_is_legal(32'(cmd_len), MAX_BEATS);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic plus the per-cycle handshake strobes that the datapath consumes.
   always_comb begin
      next_state  = state;
      cmd_fire    = 1'b0;
      wd_fire     = 1'b0;
      beat_fire   = 1'b0;
      stall_fire  = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cmd_fire = 1'b1;
               if (!cmd_legal) begin
                  next_state = S_DONE;
               end else if (cmd_wr) begin
                  next_state = S_LOAD;
               end else begin
                  next_state = S_RBUS;
               end
            end
         end
         S_LOAD: begin
            if (wd_valid) begin
               wd_fire = 1'b1;
               if (last_beat) begin
                  next_state = S_WBUS;
               end
            end
         end
         S_WBUS, S_RBUS: begin
            if (bus_ready) begin
               beat_fire = 1'b1;
               if (last_beat) begin
                  next_state = S_DONE;
               end
            end else begin
               stall_fire = 1'b1;
               if (stall_cnt == STALL_LAST) begin
                  timeout_hit = 1'b1;
                  next_state  = S_DONE;
               end
            end
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // cmd_ready is registered so that it stays low through the whole reset window
   // and only rises on the first cycle after reset is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q        <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         cnt         <= '0;
         stall_cnt   <= '0;
         err_q       <= 1'b0;
         timeout_q   <= 1'b0;
         cmd_ready_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         cmd_ready_q <= (next_state == S_IDLE);
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         if (cmd_fire) begin
            wr_q      <= cmd_wr;
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            cnt       <= '0;
            stall_cnt <= '0;
            err_q     <= !cmd_legal;
            timeout_q <= 1'b0;
         end
         if (wd_fire) begin
            cnt <= last_beat ? '0 : cnt + LEN_W'(1);
         end
         if (beat_fire) begin
            cnt       <= cnt + LEN_W'(1);
            stall_cnt <= '0;
            err_q     <= err_q | (bus_resp == RESP_ERR);
            if (state == S_RBUS) begin
               rd_valid_q <= 1'b1;
               rd_data_q  <= bus_rdata;
               rd_last_q  <= last_beat;
            end
         end
         if (stall_fire) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
            if (timeout_hit) begin
               err_q     <= 1'b1;
               timeout_q <= 1'b1;
            end
         end
      end
   end

   burst_buffer #(
      .DEPTH (MAX_BEATS),
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
   ) u_buf (
      .clk  (clk),
      .we   (wd_fire),
      .waddr(cnt[IDX_W-1:0]),
      .wdata(wd_data),
      .raddr(cnt[IDX_W-1:0]),
      .rdata(buf_rdata)
   );

   assign cmd_ready     = cmd_ready_q;
   assign wd_ready      = (state == S_LOAD);
   assign bus_valid     = in_bus;
   assign bus_wr_en     = in_bus && wr_q;
   assign bus_addr      = addr_q;
   assign bus_burst_len = len_q;
   assign bus_wdata     = (state == S_WBUS) ? buf_rdata : '0;
   assign rd_valid      = rd_valid_q;
   assign rd_data       = rd_data_q;
   assign rd_last       = rd_last_q;
   assign done          = (state == S_DONE);
   assign done_err      = (state == S_DONE) && err_q;
   assign done_timeout  = (state == S_DONE) && timeout_q;

endmodule

// File: tb/tb_bus_burst_manager.sv
// Directed + randomized bench for bus_burst_manager; a slave memory model and
// per-command expectations are computed here from the burst rules.
module tb_bus_burst_manager;
   import bus_mgr_pkg::*;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 32;
   localparam int MAX_BEATS = 16;
   localparam int LEN_W     = 5;
   localparam int TO        = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_wr = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic              wd_valid = 1'b0;
   logic              wd_ready;
   logic [DATA_W-1:0] wd_data = '0;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              done;
   logic              done_err;
   logic              done_timeout;
   logic              bus_valid;
   logic              bus_wr_en;
   logic [ADDR_W-1:0] bus_addr;
   logic [LEN_W-1:0]  bus_burst_len;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_ready = 1'b0;
   logic              bus_resp = 1'b0;
   logic [DATA_W-1:0] bus_rdata = '0;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] mem   [256];
   logic [DATA_W-1:0] wbuf  [MAX_BEATS];
   int                stall [MAX_BEATS];
   logic              resp  [MAX_BEATS];

   bus_burst_manager #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .LEN_W(LEN_W), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
      .done(done), .done_err(done_err), .done_timeout(done_timeout),
      .bus_valid(bus_valid), .bus_wr_en(bus_wr_en), .bus_addr(bus_addr),
      .bus_burst_len(bus_burst_len), .bus_wdata(bus_wdata),
      .bus_ready(bus_ready), .bus_resp(bus_resp), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic waitCmdReady();
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("cmd_ready_wait", 64'(cmd_ready), 64'd1);
   endtask

   task automatic clearPlan();
      for (int i = 0; i < MAX_BEATS; i++) begin
         stall[i] = 0;
         resp[i]  = RESP_OK;
      end
   endtask

   // One full command: expected bus sequence, read data and completion flags
   // are derived from the slave memory model and the stall/resp plan.
   task automatic applyStimulus(input bit wr, input int addr, input int len);
      bit legal;
      bit exp_err;
      bit tmo;
      logic [DATA_W-1:0] exp_rd;
      legal   = (len >= 1) && (len <= MAX_BEATS);
      exp_err = !legal;
      tmo     = 1'b0;
      waitCmdReady();
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = addr[ADDR_W-1:0];
      cmd_len   = len[LEN_W-1:0];
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr  = ADDR_W'($urandom);
      cmd_len   = LEN_W'($urandom);
      if (!legal) begin
         checkOutput("illegal_done", 64'(done), 64'd1);
         checkOutput("illegal_err", 64'(done_err), 64'd1);
         checkOutput("illegal_tmo", 64'(done_timeout), 64'd0);
         checkOutput("illegal_bus_valid", 64'(bus_valid), 64'd0);
         checkOutput("illegal_wd_ready", 64'(wd_ready), 64'd0);
         @(negedge clk);
         checkOutput("illegal_done_clear", 64'(done), 64'd0);
         checkOutput("illegal_cmd_ready", 64'(cmd_ready), 64'd1);
         return;
      end
      if (wr) begin
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               wd_valid = 1'b0;
               checkOutput("wd_ready_gap", 64'(wd_ready), 64'd1);
               @(negedge clk);
            end
            checkOutput("wd_ready", 64'(wd_ready), 64'd1);
            checkOutput("bus_idle_in_load", 64'(bus_valid), 64'd0);
            wd_valid = 1'b1;
            wd_data  = wbuf[i];
            @(negedge clk);
         end
         wd_valid = 1'b0;
         wd_data  = DATA_W'($urandom);
      end
      for (int i = 0; i < len; i++) begin
         for (int s = 0; s < stall[i]; s++) begin
            checkOutput("stall_bus_valid", 64'(bus_valid), 64'd1);
            if (wr) checkOutput("stall_wdata", 64'(bus_wdata), 64'(wbuf[i]));
            bus_ready = 1'b0;
            bus_resp  = 1'($urandom);
            @(negedge clk);
            if (!wr) checkOutput("stall_rd_valid", 64'(rd_valid), 64'd0);
            if (s + 1 == TO) begin
               tmo = 1'b1;
               break;
            end
         end
         if (tmo) break;
         checkOutput("bus_valid", 64'(bus_valid), 64'd1);
         checkOutput("bus_wr_en", 64'(bus_wr_en), 64'(wr));
         checkOutput("bus_addr", 64'(bus_addr), 64'(addr[ADDR_W-1:0]));
         checkOutput("bus_burst_len", 64'(bus_burst_len), 64'(len));
         if (wr) checkOutput("bus_wdata", 64'(bus_wdata), 64'(wbuf[i]));
         exp_rd    = mem[(addr + i) % 256];
         bus_ready = 1'b1;
         bus_resp  = resp[i];
         bus_rdata = exp_rd;
         exp_err   = exp_err | resp[i];
         if (wr) mem[(addr + i) % 256] = wbuf[i];
         @(negedge clk);
         bus_ready = 1'b0;
         bus_resp  = 1'b0;
         bus_rdata = DATA_W'($urandom);
         if (!wr) begin
            checkOutput("rd_valid", 64'(rd_valid), 64'd1);
            checkOutput("rd_data", 64'(rd_data), 64'(exp_rd));
            checkOutput("rd_last", 64'(rd_last), 64'(i == len - 1));
         end
      end
      if (tmo) begin
         exp_err = 1'b1;
         checkOutput("tmo_rd_last", 64'(rd_last), 64'd0);
      end
      checkOutput("done", 64'(done), 64'd1);
      checkOutput("done_err", 64'(done_err), 64'(exp_err));
      checkOutput("done_timeout", 64'(done_timeout), 64'(tmo));
      checkOutput("bus_valid_at_done", 64'(bus_valid), 64'd0);
      @(negedge clk);
      checkOutput("done_pulse", 64'(done), 64'd0);
      checkOutput("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      clearPlan();

      // Reset values while reset is held.
      repeat (3) @(negedge clk);
      checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("rst_bus_valid", 64'(bus_valid), 64'd0);
      checkOutput("rst_wd_ready", 64'(wd_ready), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
      checkOutput("rst_bus_addr", 64'(bus_addr), 64'd0);
      checkOutput("rst_bus_wdata", 64'(bus_wdata), 64'd0);
      checkOutput("rst_rd_data", 64'(rd_data), 64'd0);
      rst = 1'b0;
      checkOutput("rst_release_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      checkOutput("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

      // Directed write of 4 beats, then read them back.
      wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'hBEEFCAFE;
      wbuf[2] = 32'h12345678; wbuf[3] = 32'hA5A5A5A5;
      applyStimulus(1'b1, 32'h20, 4);
      applyStimulus(1'b0, 32'h20, 4);

      // Stall three cycles on beat 2 of a write.
      stall[2] = 3;
      applyStimulus(1'b1, 32'h20, 4);
      clearPlan();

      // Error response on beat 1 only.
      resp[1] = RESP_ERR;
      applyStimulus(1'b0, 32'h20, 4);
      clearPlan();

      // Slave never ready: timeout, then a normal command must still be accepted.
      stall[0] = TO;
      applyStimulus(1'b0, 32'h40, 4);
      clearPlan();
      stall[1] = TO;
      applyStimulus(1'b1, 32'h44, 3);
      clearPlan();
      applyStimulus(1'b0, 32'h20, 2);

      // Illegal lengths.
      applyStimulus(1'b1, 32'h10, 0);
      applyStimulus(1'b0, 32'h10, 17);

      // Randomized bursts against the memory model.
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < MAX_BEATS; i++) begin
            wbuf[i]  = $urandom;
            stall[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            resp[i]  = ($urandom_range(0, 7) == 0) ? RESP_ERR : RESP_OK;
         end
         applyStimulus(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(1, MAX_BEATS)));
      end
      clearPlan();

      // Reset during beat 2 of a read: bus drops next cycle, no done.
      waitCmdReady();
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h20; cmd_len = 5'd4;
      @(negedge clk);
      cmd_valid = 1'b0;
      bus_ready = 1'b1;
      bus_rdata = mem[8'h20];
      @(negedge clk);
      checkOutput("mid_rd_valid", 64'(rd_valid), 64'd1);
      checkOutput("mid_bus_valid", 64'(bus_valid), 64'd1);
      bus_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_bus_valid", 64'(bus_valid), 64'd0);
      checkOutput("mid_rst_done", 64'(done), 64'd0);
      checkOutput("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_done", 64'(done), 64'd0);
      checkOutput("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      checkOutput("post_rst_bus_valid", 64'(bus_valid), 64'd0);
      applyStimulus(1'b1, 32'h80, 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_burst_manager.md
# bus_burst_manager

Synthesizable, parametrised bus manager that replaces the behavioural write/read burst tasks with a command-driven engine. It accepts burst commands from a local client, stages write data in an internal burst buffer, and drives the shared bus (`valid/wr_en/addr/burst_len/wdata` ↔ `ready/rdata/resp`). It accumulates per-beat error responses, aborts on slave timeout, and reports one completion per command. It sits between test/traffic generators or a CPU-side adapter and the bus slave.

## Interface
- `ADDR_W`, 8, bus address width
- `DATA_W`, 32, bus data width
- `MAX_BEATS`, 16, largest legal burst; sizes the write buffer
- `LEN_W`, `$clog2(MAX_BEATS+1)`, width of burst-length fields
- `TIMEOUT`, 64, consecutive stalled cycles (`valid && !ready`) before abort; ≥1
- `clk`  in  1  sole clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when both high
- `cmd_wr`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  ADDR_W  burst start address
- `cmd_len`  in  LEN_W  beat count
- `wd_valid` / `wd_ready`  in/out  1  write-data stream handshake
- `wd_data`  in  DATA_W  write beat
- `rd_valid`  out  1  read beat valid; consumer must accept, no backpressure
- `rd_data`  out  DATA_W  read beat
- `rd_last`  out  1  final beat of the read burst
- `done`  out  1  one-cycle completion pulse
- `done_err`  out  1  valid with `done`: OR of `resp` over all beats, timeout, or illegal length
- `done_timeout`  out  1  valid with `done`: burst aborted by timeout
- `bus_valid`, `bus_wr_en`  out  1  bus request and direction
- `bus_addr`  out  ADDR_W  held constant for the whole burst (slave increments)
- `bus_burst_len`  out  LEN_W  beat count
- `bus_wdata`  out  DATA_W  current write beat
- `bus_ready`, `bus_resp`  in  1  beat accept, 1 = error on that beat
- `bus_rdata`  in  DATA_W  read beat

## Operation
- States: IDLE, LOAD, WBUS, RBUS, DONE.
- IDLE: `cmd_ready=1`. On accept, latch `cmd_wr`, `cmd_addr`, `cmd_len`; clear beat counter, stall counter, and error flag.
  - Illegal length (`cmd_len==0` or `>MAX_BEATS`) → DONE with `done_err=1`. No bus or wd activity.
  - Legal write → LOAD.
  - Legal read → RBUS.
- LOAD: `wd_ready=1`. Each `wd_valid && wd_ready` stores into `buf[cnt]` and increments `cnt`. After beat `len-1` is stored, reset `cnt` and go to WBUS.
- WBUS/RBUS: `bus_valid=1`; `bus_wr_en` = latched direction; `bus_wdata = buf[cnt]`.
  - Beat completes on a posedge with `bus_valid && bus_ready`: `err |= bus_resp`, `cnt++`, stall counter cleared.
  - In RBUS, each completing beat drives `rd_valid=1` and `rd_data=bus_rdata` (registered, next cycle). `rd_last=1` on beat `len-1`.
  - After beat `len-1` → DONE.
- Timeout: the stall counter increments on every cycle with `bus_valid && !bus_ready`. Reaching TIMEOUT → DONE with `done_err=1`, `done_timeout=1`. Remaining beats are dropped and `rd_last` is not issued.
- DONE: `done=1` for exactly one cycle, then IDLE.

## Timing
- Reset values: `cmd_ready`, `wd_ready`, `rd_valid`, `rd_last`, `done`, `done_err`, `done_timeout`, `bus_valid`, `bus_wr_en` = 0; `bus_addr`, `bus_burst_len`, `bus_wdata`, `rd_data` = 0. `cmd_ready` rises the cycle after `rst` deasserts.
- Command accepted at edge N:
  - Read: `bus_valid` high from N+1.
  - Write: `wd_ready` high from N+1. `bus_valid` high the cycle after the last wd beat.
- Zero-stall burst of L beats: `bus_valid` high for exactly L cycles. `done` in the cycle after the last beat. `cmd_ready` high one cycle later. No gaps in `bus_valid` within a burst.
- Read data latency: `rd_valid` one cycle after the accepting edge.
- Reset mid-burst: all state returns to IDLE at the sampling edge. `bus_valid` is 0 the next cycle. No `done` is issued. The buffer contents are don't-care.

## Structure
- Package `bus_mgr_pkg`: state enum `mgr_state_e`; `RESP_OK=1'b0`, `RESP_ERR=1'b1`.
- Sub-module `burst_buffer`: MAX_BEATS × DATA_W register file with write port (`we`, `waddr`, `wdata`) and asynchronous read port.
- Top-level contents: FSM, beat/stall counters, output registers.

## Test plan
- Write 4 beats to 0x20 with data DEADBEEF, BEEFCAFE, 12345678, A5A5A5A5 → `bus_valid` high 4 cycles with `bus_addr=0x20` and `bus_burst_len=4`; data in that order; `done=1`, `done_err=0`.
- Read 4 from 0x20 → `rd_data` sequence matches the previous write; `rd_last` on the 4th beat; `done_err=0`.
- Slave holds `bus_ready=0` for 3 cycles on beat 2 → `bus_wdata` held at 12345678 during the stall; burst completes; `done_timeout=0`.
- Slave returns `bus_resp=1` on beat 1 only → all 4 beats are still performed; `done_err=1`.
- `bus_ready` stuck at 0 with TIMEOUT=8 → `bus_valid` drops after 8 stalled cycles; `done_err=1`, `done_timeout=1`; the next command is accepted.
- `cmd_len=0`, then `cmd_len=17` (MAX_BEATS=16) → no bus activity; `done_err=1` each. Then assert `rst` during beat 2 of a read → `bus_valid=0` next cycle and no `done`.
